// File: rtl/lock_control_multi.sv
// Multi-slot stroke-lock controller.
// Sequences the display, touch-capture and comparator engines, arbitrates the
// shared SRAM bus, keeps NSLOT stored password strokes and a failed-attempt
// counter that triggers a timed lockout.
module lock_control_multi #(
    parameter int unsigned NSLOT   = 4,
    parameter int unsigned SLOTW   = 2,
    parameter int unsigned RGNW    = 3,
    parameter int unsigned AW      = 19,
    parameter int unsigned SDW     = 256,
    parameter int unsigned LW      = 6,
    parameter int unsigned HOLD    = 15,
    parameter int unsigned THRESH  = 8,
    parameter int unsigned MAXFAIL = 3,
    parameter int unsigned LOCKFR  = 60
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_keySet,
    input  logic                          i_keyLock,
    input  logic                          i_keyShow,
    input  logic [SLOTW-1:0]              i_slotSel,
    input  logic                          i_dispDone,
    input  logic [AW-1:0]                 i_dispAddr,
    output logic                          o_dispStart,
    output logic                          o_dispMode,
    output logic [2:0]                    o_dispRGB,
    input  logic [AW-1:0]                 i_touchAddr,
    input  logic [7:0]                    i_touchData,
    input  logic                          i_touchWE,
    input  logic                          i_strokeIRQ,
    input  logic [LW-1:0]                 i_strokeLeng,
    input  logic [SDW-1:0]                i_strokeData,
    input  logic [AW-1:0]                 i_compAddr,
    input  logic [7:0]                    i_compData,
    input  logic                          i_compWE,
    input  logic                          i_compDone,
    input  logic [7:0]                    i_compResult,
    output logic                          o_compStart,
    output logic [SDW-1:0]                o_refStroke,
    output logic [LW-1:0]                 o_refLeng,
    output logic [SDW-1:0]                o_curStroke,
    output logic [LW-1:0]                 o_curLeng,
    output logic [RGNW+AW-1:0]            o_sramA,
    output logic [7:0]                    o_sramDout,
    output logic                          o_sramWE,
    output logic                          o_sramCE,
    output logic [3:0]                    o_state,
    output logic [$clog2(MAXFAIL+1)-1:0]  o_failCnt,
    output logic                          o_locked
);

    localparam int unsigned CNTMAX = (HOLD > LOCKFR) ? HOLD : LOCKFR;
    localparam int unsigned CW     = $clog2(CNTMAX + 1);
    localparam int unsigned FW     = $clog2(MAXFAIL + 1);

    typedef enum logic [3:0] {
        WHITE   = 4'd0,
        BLK_SET = 4'd1,
        BLK_CHK = 4'd2,
        SET     = 4'd3,
        CAPT    = 4'd4,
        SHOW    = 4'd5,
        PREV    = 4'd6,
        CHECK   = 4'd7,
        YES     = 4'd8,
        NO      = 4'd9,
        LOCKOUT = 4'd10
    } state_t;

    state_t            state, nextState;
    logic [CW-1:0]     cnt, nextCnt;
    logic [FW-1:0]     failCnt, nextFail;
    logic [SLOTW-1:0]  sel, nextSel;
    logic              dispStartN, compStartN;
    logic              storeSlot, storeCur;

    logic [NSLOT-1:0]  slotValid;
    logic [SDW-1:0]    slotStroke [NSLOT];
    logic [LW-1:0]     slotLeng   [NSLOT];
    logic [SDW-1:0]    curStroke;
    logic [LW-1:0]     curLeng;

    logic              dispStartQ, compStartQ;
    logic              dispDoneQ, compDoneQ, armed;
    logic              dispEdge, compEdge;
    logic              slotOk, failFull;

    // armed stays low for the first cycle after reset so a done level that is
    // already high at release is absorbed into the history instead of firing.
    assign dispEdge = armed & i_dispDone & ~dispDoneQ;
    assign compEdge = armed & i_compDone & ~compDoneQ;
    assign slotOk   = ({1'b0, i_slotSel} < (SLOTW+1)'(NSLOT));
    assign failFull = (failCnt == FW'(MAXFAIL));

    // State, counters, pulse registers and done-edge history
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= WHITE;
            cnt        <= '0;
            failCnt    <= '0;
            sel        <= '0;
            dispStartQ <= 1'b0;
            compStartQ <= 1'b0;
            dispDoneQ  <= 1'b0;
            compDoneQ  <= 1'b0;
            armed      <= 1'b0;
        end else begin
            state      <= nextState;
            cnt        <= nextCnt;
            failCnt    <= nextFail;
            sel        <= nextSel;
            dispStartQ <= dispStartN;
            compStartQ <= compStartN;
            dispDoneQ  <= i_dispDone;
            compDoneQ  <= i_compDone;
            armed      <= 1'b1;
        end
    end

    // Stroke storage for the password slots and the latest attempt
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            slotValid <= '0;
            curStroke <= '0;
            curLeng   <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                slotStroke[i] <= '0;
                slotLeng[i]   <= '0;
            end
        end else begin
            if (storeSlot) begin
                slotStroke[sel] <= i_strokeData;
                slotLeng[sel]   <= i_strokeLeng;
                slotValid[sel]  <= 1'b1;
            end
            if (storeCur) begin
                curStroke <= i_strokeData;
                curLeng   <= i_strokeLeng;
            end
        end
    end

    // Next-state, counter, fail-count and start-pulse decisions
    always_comb begin
        nextState  = state;
        nextCnt    = cnt;
        nextFail   = failCnt;
        nextSel    = sel;
        dispStartN = 1'b0;
        compStartN = 1'b0;
        storeSlot  = 1'b0;
        storeCur   = 1'b0;
        unique case (state)
            WHITE: begin
                if (dispEdge) dispStartN = 1'b1;
                if (i_keySet) begin
                    if (slotOk) begin
                        nextSel    = i_slotSel;
                        dispStartN = 1'b1;
                        nextState  = BLK_SET;
                    end
                end else if (i_keyLock) begin
                    if (slotOk && !failFull) begin
                        nextSel    = i_slotSel;
                        dispStartN = 1'b1;
                        nextState  = BLK_CHK;
                    end
                end else if (i_keyShow) begin
                    if (slotOk && slotValid[i_slotSel]) begin
                        nextSel    = i_slotSel;
                        dispStartN = 1'b1;
                        nextCnt    = CW'(HOLD - 1);
                        nextState  = SHOW;
                    end
                end
            end
            BLK_SET: if (dispEdge) nextState = SET;
            BLK_CHK: if (dispEdge) nextState = CAPT;
            SET: begin
                if (i_strokeIRQ) begin
                    storeSlot  = 1'b1;
                    nextCnt    = CW'(HOLD - 1);
                    dispStartN = 1'b1;
                    nextState  = SHOW;
                end
            end
            CAPT: begin
                if (i_strokeIRQ) begin
                    storeCur   = 1'b1;
                    nextCnt    = CW'(HOLD - 1);
                    dispStartN = 1'b1;
                    nextState  = PREV;
                end
            end
            SHOW, YES: begin
                if (dispEdge) begin
                    dispStartN = 1'b1;
                    if (cnt != '0) nextCnt = cnt - CW'(1);
                    else           nextState = WHITE;
                end
            end
            PREV: begin
                if (dispEdge) begin
                    if (cnt != '0) begin
                        nextCnt    = cnt - CW'(1);
                        dispStartN = 1'b1;
                    end else begin
                        nextState  = CHECK;
                        compStartN = slotValid[sel];
                    end
                end
            end
            CHECK: begin
                // An empty slot cannot match, so it fails without the comparator.
                if (!slotValid[sel] || compEdge) begin
                    nextCnt    = CW'(HOLD - 1);
                    dispStartN = 1'b1;
                    if (slotValid[sel] && (i_compResult <= 8'(THRESH))) begin
                        nextFail  = '0;
                        nextState = YES;
                    end else begin
                        nextFail  = failFull ? failCnt : failCnt + FW'(1);
                        nextState = NO;
                    end
                end
            end
            NO: begin
                if (dispEdge) begin
                    dispStartN = 1'b1;
                    if (cnt != '0) begin
                        nextCnt = cnt - CW'(1);
                    end else if (failFull) begin
                        nextCnt   = CW'(LOCKFR - 1);
                        nextState = LOCKOUT;
                    end else begin
                        nextState = BLK_CHK;
                    end
                end
            end
            LOCKOUT: begin
                if (dispEdge) begin
                    dispStartN = 1'b1;
                    if (cnt != '0) begin
                        nextCnt = cnt - CW'(1);
                    end else begin
                        nextFail  = '0;
                        nextState = WHITE;
                    end
                end
            end
            default: nextState = WHITE;
        endcase
    end

    // Display mode/colour decoded from state
    always_comb begin
        o_dispMode = 1'b1;
        o_dispRGB  = 3'b000;
        unique case (state)
            WHITE, SET, CAPT: o_dispRGB  = 3'b111;
            SHOW, PREV:       o_dispMode = 1'b0;
            YES:              o_dispRGB  = 3'b010;
            NO, LOCKOUT:      o_dispRGB  = 3'b100;
            default:          o_dispRGB  = 3'b000;
        endcase
    end

    // SRAM bus arbitration: owner selected by state
    always_comb begin
        o_sramA    = '0;
        o_sramDout = '0;
        o_sramWE   = 1'b0;
        o_sramCE   = 1'b0;
        unique case (state)
            SET: begin
                o_sramCE   = 1'b1;
                o_sramWE   = i_touchWE;
                o_sramA    = {RGNW'(sel), i_touchAddr};
                o_sramDout = i_touchData;
            end
            CAPT: begin
                o_sramCE   = 1'b1;
                o_sramWE   = i_touchWE;
                o_sramA    = {RGNW'(NSLOT), i_touchAddr};
                o_sramDout = i_touchData;
            end
            SHOW: begin
                o_sramCE = 1'b1;
                o_sramA  = {RGNW'(sel), i_dispAddr};
            end
            PREV: begin
                o_sramCE = 1'b1;
                o_sramA  = {RGNW'(NSLOT), i_dispAddr};
            end
            CHECK: begin
                o_sramCE   = 1'b1;
                o_sramWE   = i_compWE;
                o_sramA    = {RGNW'(NSLOT + 1), i_compAddr};
                o_sramDout = i_compData;
            end
            default: begin
                o_sramCE = 1'b0;
            end
        endcase
    end

    assign o_dispStart = dispStartQ;
    assign o_compStart = compStartQ;
    assign o_refStroke = slotStroke[sel];
    assign o_refLeng   = slotLeng[sel];
    assign o_curStroke = curStroke;
    assign o_curLeng   = curLeng;
    assign o_state     = state;
    assign o_failCnt   = failCnt;
    assign o_locked    = (state == LOCKOUT);

endmodule

// File: tb/tb_lock_control_multi.sv
// Scoreboard bench for lock_control_multi: stimulus pushes expected display
// and comparator start events plus spot probes; a negedge monitor compares.
module tb_lock_control_multi;

    localparam logic [3:0] S_WHITE = 4'd0, S_BLKSET = 4'd1, S_BLKCHK = 4'd2,
                           S_SET = 4'd3, S_CAPT = 4'd4, S_SHOW = 4'd5,
                           S_PREV = 4'd6, S_CHECK = 4'd7, S_YES = 4'd8,
                           S_NO = 4'd9, S_LOCK = 4'd10;

    localparam int P_STATE = 0, P_FAIL = 1, P_LOCKED = 2, P_SRAMA = 3,
                   P_WE = 4, P_CE = 5, P_REFLENG = 6, P_CURLENG = 7,
                   P_DSTART = 8, P_CSTART = 9, P_DOUT = 10, P_MODE = 11,
                   P_REFLO = 12, P_CURLO = 13;

    logic          i_clk = 1'b0;
    logic          i_rst, i_keySet, i_keyLock, i_keyShow;
    logic [1:0]    i_slotSel;
    logic          i_dispDone;
    logic [18:0]   i_dispAddr, i_touchAddr, i_compAddr;
    logic [7:0]    i_touchData, i_compData, i_compResult;
    logic          i_touchWE, i_strokeIRQ, i_compWE, i_compDone;
    logic [5:0]    i_strokeLeng;
    logic [255:0]  i_strokeData;
    logic          o_dispStart, o_dispMode, o_compStart;
    logic [2:0]    o_dispRGB;
    logic [255:0]  o_refStroke, o_curStroke;
    logic [5:0]    o_refLeng, o_curLeng;
    logic [21:0]   o_sramA;
    logic [7:0]    o_sramDout;
    logic          o_sramWE, o_sramCE, o_locked;
    logic [3:0]    o_state;
    logic [1:0]    o_failCnt;

    lock_control_multi #(.NSLOT(4), .SLOTW(2), .RGNW(3), .AW(19), .SDW(256),
                         .LW(6), .HOLD(15), .THRESH(8), .MAXFAIL(3), .LOCKFR(60)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_keySet(i_keySet), .i_keyLock(i_keyLock),
        .i_keyShow(i_keyShow), .i_slotSel(i_slotSel), .i_dispDone(i_dispDone),
        .i_dispAddr(i_dispAddr), .o_dispStart(o_dispStart), .o_dispMode(o_dispMode),
        .o_dispRGB(o_dispRGB), .i_touchAddr(i_touchAddr), .i_touchData(i_touchData),
        .i_touchWE(i_touchWE), .i_strokeIRQ(i_strokeIRQ), .i_strokeLeng(i_strokeLeng),
        .i_strokeData(i_strokeData), .i_compAddr(i_compAddr), .i_compData(i_compData),
        .i_compWE(i_compWE), .i_compDone(i_compDone), .i_compResult(i_compResult),
        .o_compStart(o_compStart), .o_refStroke(o_refStroke), .o_refLeng(o_refLeng),
        .o_curStroke(o_curStroke), .o_curLeng(o_curLeng), .o_sramA(o_sramA),
        .o_sramDout(o_sramDout), .o_sramWE(o_sramWE), .o_sramCE(o_sramCE),
        .o_state(o_state), .o_failCnt(o_failCnt), .o_locked(o_locked)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic [2:0] rgb;
        logic       mode;
        logic [1:0] fail;
        logic       locked;
    } dExp_t;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } pExp_t;

    dExp_t dispQ[$];
    string compQ[$];
    pExp_t probeQ[$];
    int    checks = 0;
    int    errors = 0;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            P_STATE:   return 32'(o_state);
            P_FAIL:    return 32'(o_failCnt);
            P_LOCKED:  return 32'(o_locked);
            P_SRAMA:   return 32'(o_sramA);
            P_WE:      return 32'(o_sramWE);
            P_CE:      return 32'(o_sramCE);
            P_REFLENG: return 32'(o_refLeng);
            P_CURLENG: return 32'(o_curLeng);
            P_DSTART:  return 32'(o_dispStart);
            P_CSTART:  return 32'(o_compStart);
            P_DOUT:    return 32'(o_sramDout);
            P_MODE:    return 32'(o_dispMode);
            P_REFLO:   return o_refStroke[31:0];
            P_CURLO:   return o_curStroke[31:0];
            default:   return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: compares on every start pulse and drains pending probes
    initial begin
        forever begin
            @(negedge i_clk);
            if (o_dispStart === 1'b1) begin
                checks++;
                if (dispQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpectedDispStart: got pulse in state %0d, required none", o_state);
                end else begin
                    dExp_t e;
                    e = dispQ.pop_front();
                    if (o_state !== e.st || o_dispRGB !== e.rgb || o_dispMode !== e.mode ||
                        o_failCnt !== e.fail || o_locked !== e.locked) begin
                        errors++;
                        $display("FAIL %s: got st=%0d rgb=%b mode=%b fail=%0d lock=%b, required st=%0d rgb=%b mode=%b fail=%0d lock=%b",
                                 e.tag, o_state, o_dispRGB, o_dispMode, o_failCnt, o_locked,
                                 e.st, e.rgb, e.mode, e.fail, e.locked);
                    end
                end
            end
            if (o_compStart === 1'b1) begin
                checks++;
                if (compQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpectedCompStart: got pulse in state %0d, required none", o_state);
                end else begin
                    string t;
                    t = compQ.pop_front();
                    if (o_state !== S_CHECK) begin
                        errors++;
                        $display("FAIL %s: got state %0d, required %0d", t, o_state, S_CHECK);
                    end
                end
            end
            while (probeQ.size() > 0) begin
                pExp_t p;
                logic [31:0] a;
                p = probeQ.pop_front();
                a = actual(p.sel);
                checks++;
                if (a !== p.exp) begin
                    errors++;
                    $display("FAIL %s: got 0x%0h, required 0x%0h", p.tag, a, p.exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic frame();
        i_dispDone = 1'b1;
        tick();
        i_dispDone = 1'b0;
        tick();
    endtask

    task automatic pushD(input string tag, input logic [3:0] st, input logic [2:0] rgb,
                         input logic mode, input logic [1:0] fail, input logic locked);
        dExp_t e;
        e.tag = tag; e.st = st; e.rgb = rgb; e.mode = mode; e.fail = fail; e.locked = locked;
        dispQ.push_back(e);
    endtask

    task automatic probe(input string tag, input int sel, input logic [31:0] exp);
        pExp_t p;
        p.tag = tag; p.sel = sel; p.exp = exp;
        probeQ.push_back(p);
    endtask

    task automatic countdown(input string tag, input logic [3:0] st, input logic [2:0] rgb,
                             input logic mode, input logic [1:0] fail, input logic locked,
                             input int n);
        for (int i = 0; i < n; i++) begin
            pushD(tag, st, rgb, mode, fail, locked);
            frame();
        end
    endtask

    task automatic programSlot(input logic [1:0] s, input logic [5:0] leng, input logic [31:0] pat);
        i_slotSel = s;
        i_keySet  = 1'b1;
        pushD("setKey", S_BLKSET, 3'b000, 1'b1, 2'd0, 1'b0);
        tick();
        i_keySet  = 1'b0;
        i_slotSel = 2'd0;
        frame();
        probe("inSet", P_STATE, 32'(S_SET));
        i_touchAddr = 19'd5; i_touchData = 8'hA5; i_touchWE = 1'b1;
        probe("setSramA", P_SRAMA, 32'({3'(s), 19'd5}));
        probe("setWE", P_WE, 32'd1);
        probe("setCE", P_CE, 32'd1);
        probe("setDout", P_DOUT, 32'h0000_00A5);
        tick();
        i_touchWE = 1'b0;
        i_strokeLeng = leng; i_strokeData = {8{pat}}; i_strokeIRQ = 1'b1;
        pushD("setToShow", S_SHOW, 3'b000, 1'b0, 2'd0, 1'b0);
        tick();
        i_strokeIRQ = 1'b0;
        i_dispAddr = 19'd7;
        probe("showSramA", P_SRAMA, 32'({3'(s), 19'd7}));
        probe("showWE", P_WE, 32'd0);
        probe("showMode", P_MODE, 32'd0);
        tick();
        countdown("showFrame", S_SHOW, 3'b000, 1'b0, 2'd0, 1'b0, 14);
        pushD("showToWhite", S_WHITE, 3'b111, 1'b1, 2'd0, 1'b0);
        frame();
    endtask

    task automatic startLock(input logic [1:0] s, input logic [1:0] failNow);
        i_slotSel = s;
        i_keyLock = 1'b1;
        pushD("lockKey", S_BLKCHK, 3'b000, 1'b1, failNow, 1'b0);
        tick();
        i_keyLock = 1'b0;
        i_slotSel = 2'd0;
    endtask

    // One attempt from BLK_CHK through the result screen and its exit.
    // All expected outcomes are supplied by the caller.
    task automatic attempt(input logic [7:0] res, input logic [1:0] failBefore,
                           input bit compExp, input logic [3:0] resSt,
                           input logic [2:0] resRgb, input logic [1:0] failAfter,
                           input logic [3:0] nextSt, input logic [2:0] nextRgb,
                           input logic nextLocked);
        frame();
        probe("inCapt", P_STATE, 32'(S_CAPT));
        i_touchAddr = 19'd9; i_touchData = 8'h3C; i_touchWE = 1'b1;
        i_strokeLeng = 6'd25; i_strokeData = {8{32'hBEEF_0001}}; i_strokeIRQ = 1'b1;
        probe("captSramA", P_SRAMA, 32'({3'd4, 19'd9}));
        probe("captWE", P_WE, 32'd1);
        pushD("captToPrev", S_PREV, 3'b000, 1'b0, failBefore, 1'b0);
        tick();
        i_touchWE = 1'b0; i_strokeIRQ = 1'b0;
        probe("curLeng", P_CURLENG, 32'd25);
        probe("curStroke", P_CURLO, 32'hBEEF_0001);
        tick();
        countdown("prevFrame", S_PREV, 3'b000, 1'b0, failBefore, 1'b0, 14);
        if (compExp) begin
            compQ.push_back("compStart");
            frame();
            i_compAddr = 19'd3; i_compData = 8'h5A; i_compWE = 1'b1;
            probe("chkSramA", P_SRAMA, 32'({3'd5, 19'd3}));
            probe("chkWE", P_WE, 32'd1);
            probe("chkDout", P_DOUT, 32'h0000_005A);
            tick();
            i_compWE = 1'b0;
            i_compResult = res; i_compDone = 1'b1;
            pushD("checkResult", resSt, resRgb, 1'b1, failAfter, 1'b0);
            tick();
            i_compDone = 1'b0;
            tick();
        end else begin
            pushD("checkResultNoComp", resSt, resRgb, 1'b1, failAfter, 1'b0);
            frame();
        end
        countdown("resultFrame", resSt, resRgb, 1'b1, failAfter, 1'b0, 14);
        pushD("resultExit", nextSt, nextRgb, 1'b1,
              (nextSt == S_WHITE) ? 2'd0 : failAfter, nextLocked);
        frame();
    endtask

    initial begin
        i_rst = 1'b1; i_keySet = 1'b0; i_keyLock = 1'b0; i_keyShow = 1'b0;
        i_slotSel = '0; i_dispDone = 1'b1; i_dispAddr = '0; i_touchAddr = '0;
        i_touchData = '0; i_touchWE = 1'b0; i_strokeIRQ = 1'b0; i_strokeLeng = '0;
        i_strokeData = '0; i_compAddr = '0; i_compData = '0; i_compWE = 1'b0;
        i_compDone = 1'b0; i_compResult = '0;
        repeat (3) tick();
        probe("rstState", P_STATE, 32'd0);
        probe("rstFail", P_FAIL, 32'd0);
        probe("rstLocked", P_LOCKED, 32'd0);
        probe("rstCE", P_CE, 32'd0);
        probe("rstWE", P_WE, 32'd0);
        probe("rstDispStart", P_DSTART, 32'd0);
        probe("rstCompStart", P_CSTART, 32'd0);
        probe("rstCurLeng", P_CURLENG, 32'd0);
        probe("rstRefLeng", P_REFLENG, 32'd0);
        tick();
        // dispDone already high at reset release must not count as an edge
        i_rst = 1'b0;
        repeat (3) tick();
        i_dispDone = 1'b0;
        tick();

        pushD("whiteFrame", S_WHITE, 3'b111, 1'b1, 2'd0, 1'b0);
        frame();

        programSlot(2'd2, 6'd12, 32'hC0DE_0002);
        probe("slot2RefLeng", P_REFLENG, 32'd12);
        probe("slot2RefStroke", P_REFLO, 32'hC0DE_0002);
        tick();

        // Show of an empty slot is ignored and does not change the selection
        i_slotSel = 2'd3; i_keyShow = 1'b1;
        tick();
        i_keyShow = 1'b0;
        probe("showEmptyIgnored", P_STATE, 32'(S_WHITE));
        probe("selKept", P_REFLENG, 32'd12);
        tick();

        i_slotSel = 2'd2; i_keyShow = 1'b1;
        pushD("showKey", S_SHOW, 3'b000, 1'b0, 2'd0, 1'b0);
        tick();
        i_keyShow = 1'b0;
        countdown("showFrame2", S_SHOW, 3'b000, 1'b0, 2'd0, 1'b0, 14);
        pushD("showToWhite2", S_WHITE, 3'b111, 1'b1, 2'd0, 1'b0);
        frame();

        programSlot(2'd1, 6'd20, 32'h0000_1111);

        startLock(2'd1, 2'd0);
        attempt(8'd5, 2'd0, 1'b1, S_YES, 3'b010, 2'd0, S_WHITE, 3'b111, 1'b0);
        probe("passFail", P_FAIL, 32'd0);
        tick();

        // Score exactly at the threshold passes
        startLock(2'd1, 2'd0);
        attempt(8'd8, 2'd0, 1'b1, S_YES, 3'b010, 2'd0, S_WHITE, 3'b111, 1'b0);

        startLock(2'd1, 2'd0);
        attempt(8'd9, 2'd0, 1'b1, S_NO, 3'b100, 2'd1, S_BLKCHK, 3'b000, 1'b0);
        attempt(8'd9, 2'd1, 1'b1, S_NO, 3'b100, 2'd2, S_BLKCHK, 3'b000, 1'b0);
        attempt(8'd9, 2'd2, 1'b1, S_NO, 3'b100, 2'd3, S_LOCK, 3'b100, 1'b1);
        i_slotSel = 2'd1; i_keyLock = 1'b1;
        tick();
        i_keyLock = 1'b0;
        probe("lockoutState", P_STATE, 32'(S_LOCK));
        probe("lockoutLocked", P_LOCKED, 32'd1);
        probe("lockoutFail", P_FAIL, 32'd3);
        tick();
        countdown("lockoutFrame", S_LOCK, 3'b100, 1'b1, 2'd3, 1'b1, 59);
        pushD("lockoutExit", S_WHITE, 3'b111, 1'b1, 2'd0, 1'b0);
        frame();
        probe("afterLockFail", P_FAIL, 32'd0);
        probe("afterLockLocked", P_LOCKED, 32'd0);
        tick();

        // Reset in the middle of CHECK, with a done edge in the same cycle
        startLock(2'd1, 2'd0);
        frame();
        i_strokeIRQ = 1'b1;
        pushD("captToPrevR", S_PREV, 3'b000, 1'b0, 2'd0, 1'b0);
        tick();
        i_strokeIRQ = 1'b0;
        countdown("prevFrameR", S_PREV, 3'b000, 1'b0, 2'd0, 1'b0, 14);
        compQ.push_back("compStartR");
        frame();
        i_compWE = 1'b1; i_compResult = 8'd0; i_compDone = 1'b1; i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        probe("midRstState", P_STATE, 32'(S_WHITE));
        probe("midRstCE", P_CE, 32'd0);
        probe("midRstWE", P_WE, 32'd0);
        probe("midRstCompStart", P_CSTART, 32'd0);
        probe("midRstDispStart", P_DSTART, 32'd0);
        probe("midRstRefLeng", P_REFLENG, 32'd0);
        probe("midRstCurLeng", P_CURLENG, 32'd0);
        tick();
        i_compWE = 1'b0; i_compDone = 1'b0;
        repeat (2) tick();
        i_slotSel = 2'd1; i_keyShow = 1'b1;
        tick();
        i_keyShow = 1'b0;
        probe("slot1Cleared", P_STATE, 32'(S_WHITE));
        tick();

        // Unprogrammed slot: no comparator start, immediate fail
        startLock(2'd3, 2'd0);
        attempt(8'd0, 2'd0, 1'b0, S_NO, 3'b100, 2'd1, S_BLKCHK, 3'b000, 1'b0);
        probe("emptySlotFail", P_FAIL, 32'd1);
        tick();
        repeat (2) tick();

        checks++;
        if (dispQ.size() != 0 || compQ.size() != 0) begin
            errors++;
            $display("FAIL pendingEvents: got %0d disp / %0d comp outstanding, required 0 / 0",
                     dispQ.size(), compQ.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
